// File: rtl/floo_ep_pkg.sv
// Shared types for the mesh traffic endpoint: tile coordinates, flit layout
// and the injection state machine encoding.
package floo_ep_pkg;

  localparam int unsigned CoordWidth   = 4;
  localparam int unsigned SeqWidth     = 16;
  localparam int unsigned IdxWidth     = 8;
  localparam int unsigned PayloadWidth = 32;

  typedef struct packed {
    logic [CoordWidth-1:0] x;
    logic [CoordWidth-1:0] y;
  } xy_id_t;

  typedef struct packed {
    xy_id_t                  dst_id;
    xy_id_t                  src_id;
    logic [SeqWidth-1:0]     seq;
    logic [IdxWidth-1:0]     idx;
    logic                    last;
    logic [PayloadWidth-1:0] payload;
  } ep_flit_t;

  typedef enum logic {
    TxIdle = 1'b0,
    TxSend = 1'b1
  } tx_state_e;

endpackage

// File: rtl/floo_ep_rx_checker.sv
// Receive side of the endpoint: picks one VC per cycle, checks each accepted
// flit against the tile id and the running flit index, keeps saturating stats.
module floo_ep_rx_checker
  import floo_ep_pkg::*;
#(
  parameter int unsigned NumVirtChannels = 1,
  parameter int unsigned CntWidth        = 32
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  xy_id_t                     id_i,
  input  logic [NumVirtChannels-1:0] valid_i,
  output logic [NumVirtChannels-1:0] ready_o,
  input  ep_flit_t                   data_i,
  input  logic                       rx_en_i,
  input  logic                       clear_i,
  output logic [CntWidth-1:0]        rx_flits_o,
  output logic [CntWidth-1:0]        rx_pkts_o,
  output logic [15:0]                rx_errs_o,
  output logic                       err_o
);

  logic [IdxWidth-1:0] exp_idx_q;
  logic                rx_hs;
  logic                flit_err;

  function automatic logic [CntWidth-1:0] sat_inc_cnt(input logic [CntWidth-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [15:0] sat_inc_err(input logic [15:0] v);
    return (&v) ? v : v + 16'd1;
  endfunction

  // Fixed-priority grant: only the lowest-indexed requesting VC is accepted.
  always_comb begin
    logic found;
    ready_o = '0;
    found   = 1'b0;
    if (rx_en_i) begin
      for (int v = 0; v < NumVirtChannels; v++) begin
        if (valid_i[v] && !found) begin
          ready_o[v] = 1'b1;
          found      = 1'b1;
        end
      end
    end
  end

  assign rx_hs    = |(valid_i & ready_o);
  assign flit_err = (data_i.dst_id != id_i) || (data_i.idx != exp_idx_q);

  // Index tracking and statistics; clear takes priority over a same-cycle flit.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      exp_idx_q  <= '0;
      rx_flits_o <= '0;
      rx_pkts_o  <= '0;
      rx_errs_o  <= '0;
      err_o      <= 1'b0;
    end else begin
      if (rx_hs) begin
        // Following the received index lets the checker re-lock after a skip.
        exp_idx_q <= data_i.last ? '0 : data_i.idx + 1'b1;
      end
      if (clear_i) begin
        rx_flits_o <= '0;
        rx_pkts_o  <= '0;
        rx_errs_o  <= '0;
        err_o      <= 1'b0;
      end else if (rx_hs) begin
        rx_flits_o <= sat_inc_cnt(rx_flits_o);
        if (data_i.last) rx_pkts_o <= sat_inc_cnt(rx_pkts_o);
        if (flit_err) begin
          rx_errs_o <= sat_inc_err(rx_errs_o);
          err_o     <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/floo_mesh_endpoint.sv
// Mesh tile traffic endpoint: injects configurable packet bursts toward the
// router and checks/counts flits ejected to this tile.
module floo_mesh_endpoint
  import floo_ep_pkg::*;
#(
  parameter  int unsigned NumVirtChannels = 1,
  parameter  int unsigned CntWidth        = 32,
  localparam int unsigned VcWidth = (NumVirtChannels > 1) ? $clog2(NumVirtChannels) : 1
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  xy_id_t                     id_i,
  input  logic                       start_i,
  input  xy_id_t                     dst_id_i,
  input  logic [15:0]                num_pkts_i,
  input  logic [7:0]                 pkt_len_i,
  input  logic [VcWidth-1:0]         vc_sel_i,
  output logic                       busy_o,
  output logic                       done_o,
  output logic [NumVirtChannels-1:0] valid_o,
  input  logic [NumVirtChannels-1:0] ready_i,
  output ep_flit_t                   data_o,
  input  logic [NumVirtChannels-1:0] valid_i,
  output logic [NumVirtChannels-1:0] ready_o,
  input  ep_flit_t                   data_i,
  input  logic                       rx_en_i,
  input  logic                       clear_i,
  output logic [CntWidth-1:0]        rx_flits_o,
  output logic [CntWidth-1:0]        rx_pkts_o,
  output logic [15:0]                rx_errs_o,
  output logic                       err_o
);

  tx_state_e           state_q, state_d;
  logic [15:0]         pkt_cnt_q, pkt_cnt_d;
  logic [7:0]          flit_idx_q, flit_idx_d;
  logic                done_q, done_d;
  logic                latch_cfg;
  xy_id_t              dst_q;
  logic [15:0]         num_pkts_q;
  logic [7:0]          pkt_len_q;
  logic [VcWidth-1:0]  vc_q;
  logic [VcWidth-1:0]  vc_clamped;
  logic                tx_hs;
  logic                flit_last;
  logic                pkt_last;

  // Out-of-range VC requests fall back to VC 0 rather than going nowhere.
  assign vc_clamped = (32'(vc_sel_i) >= NumVirtChannels) ? '0 : vc_sel_i;

  assign flit_last = (flit_idx_q == pkt_len_q - 8'd1);
  assign pkt_last  = (pkt_cnt_q == num_pkts_q - 16'd1);
  assign tx_hs     = |(valid_o & ready_i);
  assign busy_o    = (state_q == TxSend);
  assign done_o    = done_q;

  // Injection state and position counters.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= TxIdle;
      pkt_cnt_q  <= '0;
      flit_idx_q <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pkt_cnt_q  <= pkt_cnt_d;
      flit_idx_q <= flit_idx_d;
      done_q     <= done_d;
    end
  end

  // Burst configuration captured at launch; only meaningful while busy.
  always_ff @(posedge clk_i) begin
    if (latch_cfg) begin
      dst_q      <= dst_id_i;
      num_pkts_q <= num_pkts_i;
      pkt_len_q  <= pkt_len_i;
      vc_q       <= vc_clamped;
    end
  end

  // Next-state logic: launch, per-flit advance and burst completion.
  always_comb begin
    state_d    = state_q;
    pkt_cnt_d  = pkt_cnt_q;
    flit_idx_d = flit_idx_q;
    done_d     = 1'b0;
    latch_cfg  = 1'b0;
    case (state_q)
      TxIdle: begin
        if (start_i) begin
          if (num_pkts_i != 16'd0 && pkt_len_i != 8'd0) begin
            state_d    = TxSend;
            latch_cfg  = 1'b1;
            pkt_cnt_d  = '0;
            flit_idx_d = '0;
          end else begin
            // Empty burst still reports completion so callers never stall.
            done_d = 1'b1;
          end
        end
      end
      TxSend: begin
        if (tx_hs) begin
          if (flit_last) begin
            flit_idx_d = '0;
            pkt_cnt_d  = pkt_cnt_q + 16'd1;
            if (pkt_last) begin
              state_d = TxIdle;
              done_d  = 1'b1;
            end
          end else begin
            flit_idx_d = flit_idx_q + 8'd1;
          end
        end
      end
      default: state_d = TxIdle;
    endcase
  end

  // Flit presentation: one-hot valid on the chosen VC, data zero when idle.
  always_comb begin
    valid_o = '0;
    data_o  = '0;
    if (busy_o) begin
      for (int v = 0; v < NumVirtChannels; v++) begin
        valid_o[v] = (vc_q == VcWidth'(v));
      end
      data_o.dst_id  = dst_q;
      data_o.src_id  = id_i;
      data_o.seq     = pkt_cnt_q;
      data_o.idx     = flit_idx_q;
      data_o.last    = flit_last;
      data_o.payload = PayloadWidth'({pkt_cnt_q, flit_idx_q});
    end
  end

  floo_ep_rx_checker #(
    .NumVirtChannels(NumVirtChannels),
    .CntWidth       (CntWidth)
  ) u_rx_checker (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .id_i      (id_i),
    .valid_i   (valid_i),
    .ready_o   (ready_o),
    .data_i    (data_i),
    .rx_en_i   (rx_en_i),
    .clear_i   (clear_i),
    .rx_flits_o(rx_flits_o),
    .rx_pkts_o (rx_pkts_o),
    .rx_errs_o (rx_errs_o),
    .err_o     (err_o)
  );

endmodule
